ecc_op_sequencer: RTL
=====================

Name: ecc_op_sequencer

Overview:
- Control FSM that sequences the ECC datapath for one operation per start request.
- Operations: encode, decode, or full channel (encode, then noise injection, then decode).
- Drives a walking one-cycle enable through the encoder stages, the noise stage and the decoder stages. Holds a latched, stable work_mod for the datapath while an operation runs.
- Sits between the APB register file (start/ctrl/work_mod) and the enc/noise/dec stage enables. Reports busy, done and error status back to the register file.

Parameters:
- AMBA_WORD, 32, width of the work_mod register field.
- ENC_STAGES, 2, number of encoder pipeline stages (1..8).
- DEC_STAGES, 3, number of decoder pipeline stages (1..8).

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous reset, active-low
- start  input  1  one-cycle pulse: CTRL register written
- abort  input  1  synchronous cancel of the current operation
- ctrl  input  2  00 encode, 01 decode, 10 full channel, 11 illegal
- work_mod  input  AMBA_WORD  00 = 8-bit, 01 = 16-bit, 10 = 32-bit codeword; any other value is illegal
- clr_status  input  1  clears the sticky overrun flag
- work_mod_q  output  AMBA_WORD  work_mod latched at the accepted start
- enc_en  output  ENC_STAGES  per-stage encoder enable, one-hot or zero
- noise_en  output  1  noise stage enable
- dec_en  output  DEC_STAGES  per-stage decoder enable, one-hot or zero
- busy  output  1  operation in progress
- op_done  output  1  one-cycle completion pulse
- err_illegal  output  1  qualifies op_done: operation rejected
- overrun  output  1  sticky: start arrived while busy

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; stage counter 0.
- States and counter:
  - States: IDLE, ENC, NOISE, DEC, DONE.
  - A 3-bit stage counter indexes the current stage within ENC or DEC.
- Accepting start:
  - start is accepted only in IDLE or DONE.
  - On acceptance, ctrl and work_mod are latched and work_mod_q updates next cycle.
- Legal operation transitions:
  - Encode (ctrl 00): enter ENC with counter = 0.
  - Decode (ctrl 01): enter DEC with counter = 0.
  - Full channel (ctrl 10): enter ENC with counter = 0.
- Illegal operation (ctrl = 11, or work_mod not in {0,1,2}):
  - Go to DONE with err_illegal = 1.
  - No stage enables are asserted.
- ENC state:
  - enc_en[counter] = 1.
  - If counter < ENC_STAGES-1, increment the counter.
  - Otherwise go to NOISE for full channel, or DONE for encode.
- NOISE state: noise_en = 1 for exactly one cycle, then DEC with counter = 0.
- DEC state:
  - dec_en[counter] = 1.
  - Step like ENC; after the last stage go to DONE.
- DONE state:
  - op_done = 1 for one cycle; err_illegal is valid that same cycle and 0 otherwise.
  - Next state is IDLE, or a new operation if start is accepted in DONE (back-to-back, no bubble).
- Latency, with start sampled at cycle 0:
  - First stage enable at cycle 1.
  - op_done at cycle ENC_STAGES+1 (encode), DEC_STAGES+1 (decode), or ENC_STAGES+DEC_STAGES+2 (full channel).
  - Illegal: op_done at cycle 1.
- busy: 1 in ENC, NOISE and DEC; 0 in IDLE and DONE.
- Enable exclusivity: at most one bit across enc_en, noise_en and dec_en is set in any cycle.
- work_mod_q stays constant from acceptance until the next accepted start; it does not return to 0 at DONE.
- Start while busy:
  - The request is ignored and the current operation is unaffected.
  - overrun is set next cycle and held until clr_status.
  - If clr_status and an ignored start occur in the same cycle, overrun stays 1 (set wins).
- Abort:
  - In any state, abort returns the FSM to IDLE next cycle.
  - All enables drop to 0 and no op_done is issued.
  - abort with start in the same cycle: abort wins and start is dropped without setting overrun.
- Reset mid-operation: immediate return to IDLE with all outputs 0, regardless of clock.

Decomposition:
- Package ecc_pkg:
  - Operation enum op_e (OP_ENC = 2'b00, OP_DEC = 2'b01, OP_FULL = 2'b10, OP_ILL = 2'b11).
  - State enum seq_state_e.
  - Localparams for the three legal work_mod codes, shared with the encoder/decoder stages.
- Sub-module: none required. The one-hot stage decoder is a small function in ecc_pkg, stage_onehot(counter, width).

Test Plan (ENC_STAGES = 2, DEC_STAGES = 3):
- Encode: start with ctrl = 00, work_mod = 2 at cycle 0 -> enc_en = 01 at cycle 1, 10 at cycle 2; op_done at cycle 3; busy high at cycles 1-2; work_mod_q = 2 from cycle 1.
- Full channel: ctrl = 10, work_mod = 1 -> enc_en at cycles 1-2, noise_en at cycle 3, dec_en = 001/010/100 at cycles 4-6; op_done at cycle 7; never two enables high in one cycle.
- Illegal requests: ctrl = 11, then ctrl = 00 with work_mod = 3 -> each gives op_done with err_illegal = 1 one cycle after start; no stage enables asserted.
- Overrun and back-to-back:
  - Decode started, second start at cycle 2 -> overrun = 1 at cycle 3; op_done still at cycle 4.
  - Start at cycle 4 (DONE) -> dec_en = 001 at cycle 5.
  - clr_status -> overrun = 0.
- Abort: full channel, abort at cycle 4 -> cycle 5 IDLE, all enables 0; no op_done in the following 10 cycles.
- Reset: rst low at cycle 2 of encode -> all outputs 0 immediately; after release, a new encode completes with op_done at cycle 3.

Source files
------------

// File: rtl/ecc_pkg.sv
// Shared types and constants for the ECC datapath control: operation codes,
// sequencer states, legal work_mod codes and the stage one-hot decoder.
package ecc_pkg;

    typedef enum logic [1:0] {
        OP_ENC  = 2'b00,
        OP_DEC  = 2'b01,
        OP_FULL = 2'b10,
        OP_ILL  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ENC   = 3'd1,
        S_NOISE = 3'd2,
        S_DEC   = 3'd3,
        S_DONE  = 3'd4
    } seq_state_e;

    localparam logic [1:0] WM_8  = 2'd0;
    localparam logic [1:0] WM_16 = 2'd1;
    localparam logic [1:0] WM_32 = 2'd2;

    // Counters at or beyond the stage count decode to all-zero.
    function automatic logic [7:0] stage_onehot(input logic [2:0] counter,
                                                input logic [3:0] width);
        logic [7:0] oh;
        oh = 8'd0;
        if ({1'b0, counter} < width) begin
            oh[counter] = 1'b1;
        end else begin
            oh = 8'd0;
        end
        return oh;
    endfunction

endpackage

// File: rtl/ecc_op_sequencer.sv
// Control FSM walking a one-cycle enable through the encoder, noise and
// decoder stages for each accepted start request.
module ecc_op_sequencer
    import ecc_pkg::*;
#(
    parameter int AMBA_WORD  = 32,
    parameter int ENC_STAGES = 2,
    parameter int DEC_STAGES = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [1:0]            ctrl,
    input  logic [AMBA_WORD-1:0]  work_mod,
    input  logic                  clr_status,
    output logic [AMBA_WORD-1:0]  work_mod_q,
    output logic [ENC_STAGES-1:0] enc_en,
    output logic                  noise_en,
    output logic [DEC_STAGES-1:0] dec_en,
    output logic                  busy,
    output logic                  op_done,
    output logic                  err_illegal,
    output logic                  overrun
);

    seq_state_e           state_q, state_d;
    logic [2:0]           cnt_q, cnt_d;
    op_e                  op_q, op_d;
    logic                 ill_q, ill_d;
    logic [AMBA_WORD-1:0] work_mod_d;
    logic                 overrun_d;
    logic                 wm_legal_s;
    logic                 in_op_s;

    assign wm_legal_s = (work_mod == {{(AMBA_WORD-2){1'b0}}, WM_8})  ||
                        (work_mod == {{(AMBA_WORD-2){1'b0}}, WM_16}) ||
                        (work_mod == {{(AMBA_WORD-2){1'b0}}, WM_32});
    assign in_op_s    = (state_q == S_ENC) || (state_q == S_NOISE) || (state_q == S_DEC);

    // State, counter and latched request registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 3'd0;
            op_q       <= OP_ENC;
            ill_q      <= 1'b0;
            work_mod_q <= {AMBA_WORD{1'b0}};
            overrun    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            ill_q      <= ill_d;
            work_mod_q <= work_mod_d;
            overrun    <= overrun_d;
        end
    end

    // Next-state logic; abort overrides everything, including a same-cycle start.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        ill_d      = ill_q;
        work_mod_d = work_mod_q;
        // An ignored start wins over a same-cycle clear.
        if (start && !abort && in_op_s) begin
            overrun_d = 1'b1;
        end else if (clr_status) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun;
        end

        if (abort) begin
            state_d = S_IDLE;
            cnt_d   = 3'd0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        op_d       = op_e'(ctrl);
                        work_mod_d = work_mod;
                        cnt_d      = 3'd0;
                        if ((op_e'(ctrl) == OP_ILL) || !wm_legal_s) begin
                            ill_d   = 1'b1;
                            state_d = S_DONE;
                        end else if (op_e'(ctrl) == OP_DEC) begin
                            ill_d   = 1'b0;
                            state_d = S_DEC;
                        end else begin
                            ill_d   = 1'b0;
                            state_d = S_ENC;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_ENC: begin
                    if (cnt_q < 3'(ENC_STAGES-1)) begin
                        cnt_d = cnt_q + 3'd1;
                    end else begin
                        cnt_d   = 3'd0;
                        state_d = (op_q == OP_FULL) ? S_NOISE : S_DONE;
                    end
                end
                S_NOISE: begin
                    cnt_d   = 3'd0;
                    state_d = S_DEC;
                end
                S_DEC: begin
                    if (cnt_q < 3'(DEC_STAGES-1)) begin
                        cnt_d = cnt_q + 3'd1;
                    end else begin
                        cnt_d   = 3'd0;
                        state_d = S_DONE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = 3'd0;
                end
            endcase
        end
    end

    // Moore outputs decoded from the registered state only.
    always_comb begin
        enc_en      = {ENC_STAGES{1'b0}};
        noise_en    = 1'b0;
        dec_en      = {DEC_STAGES{1'b0}};
        busy        = 1'b0;
        op_done     = 1'b0;
        err_illegal = 1'b0;
        case (state_q)
            S_ENC: begin
                enc_en = ENC_STAGES'(stage_onehot(cnt_q, 4'(ENC_STAGES)));
                busy   = 1'b1;
            end
            S_NOISE: begin
                noise_en = 1'b1;
                busy     = 1'b1;
            end
            S_DEC: begin
                dec_en = DEC_STAGES'(stage_onehot(cnt_q, 4'(DEC_STAGES)));
                busy   = 1'b1;
            end
            S_DONE: begin
                op_done     = 1'b1;
                err_illegal = ill_q;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule
